// File: rtl/eth_frame_ctrl_if.sv
// Ethernet frame controller bus: byte stream in, decode status out.
interface eth_frame_ctrl_if #(
    parameter int unsigned CNT_W = 11
);
    logic             control;
    logic [7:0]       data;
    logic             enable_header;
    logic             enable_payload;
    logic [15:0]      type_length;
    logic [CNT_W-1:0] payload_count;
    logic             frame_done;
    logic             frame_error;
    logic [1:0]       err_code;

    // Stream source side
    modport master (
        output control, data,
        input  enable_header, enable_payload, type_length, payload_count,
        input  frame_done, frame_error, err_code
    );

    // Frame controller side
    modport slave (
        input  control, data,
        output enable_header, enable_payload, type_length, payload_count,
        output frame_done, frame_error, err_code
    );
endinterface

// File: rtl/eth_frame_ctrl.sv
// Ethernet frame delimiter: header capture, payload length policing, end-of-frame status.
module eth_frame_ctrl #(
    parameter int unsigned HDR_BYTES   = 14,
    parameter int unsigned TL_OFFSET   = 12,
    parameter int unsigned MIN_PAYLOAD = 46,
    parameter int unsigned MAX_PAYLOAD = 1500,
    parameter int unsigned CNT_W       = 11
) (
    input logic             clock,
    input logic             reset,
    eth_frame_ctrl_if.slave bus
);
    localparam int unsigned HDR_W = $clog2(HDR_BYTES + 1);

    localparam logic [2:0] SYNC    = 3'd0;
    localparam logic [2:0] IDLE    = 3'd1;
    localparam logic [2:0] HEADER  = 3'd2;
    localparam logic [2:0] PAYLOAD = 3'd3;
    localparam logic [2:0] DRAIN   = 3'd4;

    localparam logic [15:0]      TYPE_MIN = 16'h0600;
    localparam logic [15:0]      MAX16    = 16'(MAX_PAYLOAD);
    localparam logic [15:0]      MIN16    = 16'(MIN_PAYLOAD);
    localparam logic [CNT_W-1:0] MAXC     = CNT_W'(MAX_PAYLOAD);
    localparam logic [CNT_W-1:0] MINC     = CNT_W'(MIN_PAYLOAD);

    logic [2:0]       state, state_nxt;
    logic [HDR_W-1:0] hdr_cnt, hdr_nxt, hdr_idx;
    logic [15:0]      type_length, tl_nxt;
    logic [CNT_W-1:0] payload_count, cnt_nxt, expected;
    logic [1:0]       err_latch, err_nxt;
    logic             frame_done, done_nxt;
    logic             frame_error, error_nxt;
    logic [1:0]       err_code, code_nxt;
    logic             len_mode, type_mode, reject_beat;

    // State and datapath registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= SYNC;
            hdr_cnt       <= '0;
            type_length   <= '0;
            payload_count <= '0;
            err_latch     <= '0;
            frame_done    <= 1'b0;
            frame_error   <= 1'b0;
            err_code      <= '0;
        end else begin
            state         <= state_nxt;
            hdr_cnt       <= hdr_nxt;
            type_length   <= tl_nxt;
            payload_count <= cnt_nxt;
            err_latch     <= err_nxt;
            frame_done    <= done_nxt;
            frame_error   <= error_nxt;
            err_code      <= code_nxt;
        end
    end

    // Next-state, header capture, payload counting and end-of-frame status
    always_comb begin
        state_nxt = state;
        hdr_nxt   = hdr_cnt;
        tl_nxt    = type_length;
        cnt_nxt   = payload_count;
        err_nxt   = err_latch;
        done_nxt  = 1'b0;
        error_nxt = 1'b0;
        code_nxt  = 2'd0;

        // Header byte 0 arrives in IDLE, so its index is implicit
        hdr_idx = (state == IDLE) ? '0 : hdr_cnt;
        if ((state == IDLE || state == HEADER) && bus.control) begin
            if (hdr_idx == HDR_W'(TL_OFFSET))     tl_nxt[15:8] = bus.data;
            if (hdr_idx == HDR_W'(TL_OFFSET + 1)) tl_nxt[7:0]  = bus.data;
        end

        // Classify on the post-capture value so the last header beat can decide
        len_mode    = (tl_nxt <= MAX16);
        type_mode   = (tl_nxt >= TYPE_MIN);
        expected    = (tl_nxt < MIN16) ? MINC : CNT_W'(tl_nxt);
        reject_beat = type_mode && (payload_count == MAXC);

        case (state)
            SYNC: begin
                if (!bus.control) state_nxt = IDLE;
            end
            IDLE: begin
                if (bus.control) begin
                    hdr_nxt   = HDR_W'(1);
                    cnt_nxt   = '0;
                    err_nxt   = 2'd0;
                    state_nxt = HEADER;
                end
            end
            HEADER: begin
                if (bus.control) begin
                    hdr_nxt = hdr_cnt + HDR_W'(1);
                    if (hdr_cnt == HDR_W'(HDR_BYTES - 1)) begin
                        if (!len_mode && !type_mode) begin
                            err_nxt   = 2'd3;
                            state_nxt = DRAIN;
                        end else begin
                            state_nxt = PAYLOAD;
                        end
                    end
                end else begin
                    state_nxt = IDLE;
                    error_nxt = 1'b1;
                    code_nxt  = 2'd1;
                end
            end
            PAYLOAD: begin
                if (bus.control) begin
                    if (reject_beat) begin
                        err_nxt   = 2'd3;
                        state_nxt = DRAIN;
                    end else begin
                        cnt_nxt = (payload_count == MAXC) ? payload_count
                                                          : payload_count + CNT_W'(1);
                        if (len_mode && cnt_nxt == expected) state_nxt = DRAIN;
                    end
                end else begin
                    state_nxt = IDLE;
                    if (len_mode || payload_count < MINC) begin
                        error_nxt = 1'b1;
                        code_nxt  = 2'd2;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (!bus.control) begin
                    state_nxt = IDLE;
                    if (err_latch != 2'd0) begin
                        error_nxt = 1'b1;
                        code_nxt  = err_latch;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            default: state_nxt = SYNC;
        endcase
    end

    // Beat-qualifying enables follow control in the same cycle
    assign bus.enable_header  = bus.control && (state == IDLE || state == HEADER);
    assign bus.enable_payload = bus.control && (state == PAYLOAD) && !reject_beat;

    assign bus.type_length    = type_length;
    assign bus.payload_count  = payload_count;
    assign bus.frame_done     = frame_done;
    assign bus.frame_error    = frame_error;
    assign bus.err_code       = err_code;
endmodule

// File: tb/tb_eth_frame_ctrl.sv
// Directed, table-driven bench for eth_frame_ctrl.
module tb_eth_frame_ctrl;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    eth_frame_ctrl_if #(.CNT_W(11)) bus();

    eth_frame_ctrl #(
        .HDR_BYTES(14), .TL_OFFSET(12), .MIN_PAYLOAD(46),
        .MAX_PAYLOAD(1500), .CNT_W(11)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus(bus)
    );

    typedef struct {
        logic [15:0] tl;
        int hdr_n;
        int pay_n;
        int tail_n;
        int exp_eh;
        int exp_ep;
        int exp_done;
        int exp_err;
        int exp_code;
        int exp_cnt;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    int n_pass = 0;
    int n_total = 0;
    int n_eh, n_ep, n_done, n_err, last_code;
    int n_stray = 0;

    task automatic check(input string name, input int actual, input int expected);
        n_total++;
        if (actual !== expected)
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        else
            n_pass++;
    endtask

    task automatic clear_counts();
        n_eh = 0; n_ep = 0; n_done = 0; n_err = 0; last_code = 0;
    endtask

    // One cycle: drive on the falling edge, sample shortly after
    task automatic step(input logic r, input logic c, input logic [7:0] d);
        @(negedge clk);
        rst = r;
        bus.control = c;
        bus.data = d;
        #1;
        if (bus.enable_header)  n_eh++;
        if (bus.enable_payload) n_ep++;
        if (bus.frame_done)     n_done++;
        if (bus.frame_error) begin
            n_err++;
            last_code = int'(bus.err_code);
        end else if (bus.err_code != 2'd0) begin
            n_stray++;
        end
    endtask

    function automatic logic [7:0] hdr_byte(input int i, input logic [15:0] tl);
        if (i == 12) return tl[15:8];
        if (i == 13) return tl[7:0];
        return 8'(i);
    endfunction

    task automatic apply_vec(input int idx, input vec_t v);
        clear_counts();
        for (int i = 0; i < v.hdr_n; i++)  step(1'b0, 1'b1, hdr_byte(i, v.tl));
        for (int i = 0; i < v.pay_n; i++)  step(1'b0, 1'b1, 8'(i));
        for (int i = 0; i < v.tail_n; i++) step(1'b0, 1'b1, 8'hAA);
        for (int i = 0; i < 3; i++)        step(1'b0, 1'b0, 8'h00);
        check($sformatf("v%0d enable_header cycles", idx), n_eh, v.exp_eh);
        check($sformatf("v%0d enable_payload cycles", idx), n_ep, v.exp_ep);
        check($sformatf("v%0d frame_done pulses", idx), n_done, v.exp_done);
        check($sformatf("v%0d frame_error pulses", idx), n_err, v.exp_err);
        check($sformatf("v%0d err_code", idx), last_code, v.exp_code);
        check($sformatf("v%0d payload_count", idx), int'(bus.payload_count), v.exp_cnt);
        if (v.hdr_n >= 14)
            check($sformatf("v%0d type_length", idx), int'(bus.type_length), int'(v.tl));
    endtask

    initial begin
        //          tl        hdr pay  tail eh  ep    done err code cnt
        vecs[0]  = '{16'h0800, 14, 60,   0, 14, 60,   1, 0, 0, 60};
        vecs[1]  = '{16'h0020, 14, 46,   4, 14, 46,   1, 0, 0, 46};
        vecs[2]  = '{16'h0800, 11, 0,    0, 11, 0,    0, 1, 1, 0};
        vecs[3]  = '{16'h0064, 14, 80,   0, 14, 80,   0, 1, 2, 80};
        vecs[4]  = '{16'h86DD, 14, 1505, 0, 14, 1500, 0, 1, 3, 1500};
        vecs[5]  = '{16'h05FF, 14, 10,   0, 14, 0,    0, 1, 3, 0};
        vecs[6]  = '{16'h0800, 14, 20,   0, 14, 20,   0, 1, 2, 20};
        vecs[7]  = '{16'h0800, 14, 46,   0, 14, 46,   1, 0, 0, 46};
        vecs[8]  = '{16'h0064, 14, 100,  4, 14, 100,  1, 0, 0, 100};
        vecs[9]  = '{16'h05DC, 14, 1500, 4, 14, 1500, 1, 0, 0, 1500};
        vecs[10] = '{16'h0800, 14, 1500, 0, 14, 1500, 1, 0, 0, 1500};
        vecs[11] = '{16'h05DD, 14, 3,    0, 14, 0,    0, 1, 3, 0};
        vecs[12] = '{16'h0000, 14, 46,   2, 14, 46,   1, 0, 0, 46};
        vecs[13] = '{16'h0010, 14, 30,   0, 14, 30,   0, 1, 2, 30};

        // Reset held with control high: everything cleared, enables low
        rst = 1'b1;
        bus.control = 1'b1;
        bus.data = 8'h55;
        repeat (3) @(negedge clk);
        #1;
        check("reset enable_header", int'(bus.enable_header), 0);
        check("reset enable_payload", int'(bus.enable_payload), 0);
        check("reset type_length", int'(bus.type_length), 0);
        check("reset payload_count", int'(bus.payload_count), 0);
        check("reset frame_done", int'(bus.frame_done), 0);
        check("reset frame_error", int'(bus.frame_error), 0);
        check("reset err_code", int'(bus.err_code), 0);

        // Out of reset with control still high: stays in sync hunt
        clear_counts();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h11);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 8'h00);
        check("sync enables", n_eh + n_ep, 0);
        check("sync pulses", n_done + n_err, 0);

        for (int k = 0; k < NV; k++) apply_vec(k, vecs[k]);

        // Reset at payload beat 30 with control held high afterwards
        clear_counts();
        for (int i = 0; i < 14; i++) step(1'b0, 1'b1, hdr_byte(i, 16'h0800));
        for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 8'(i));
        check("pre-reset enable_payload", n_ep, 30);
        step(1'b1, 1'b1, 8'h77);
        clear_counts();
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'(i));
        for (int i = 0; i < 3; i++)  step(1'b0, 1'b0, 8'h00);
        check("midreset enable_header", n_eh, 0);
        check("midreset enable_payload", n_ep, 0);
        check("midreset pulses", n_done + n_err, 0);
        check("midreset payload_count", int'(bus.payload_count), 0);
        check("midreset type_length", int'(bus.type_length), 0);
        apply_vec(100, vecs[0]);

        check("err_code outside error pulse", n_stray, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
